vram_arbiter: RTL and testbench

Time-multiplexes the single-port video RAM between two requesters: the video fetch engine and the CPU bus bridge. Runs on the dot clock, issues at most one RAM access per cycle, and returns read data tagged to its owner. Video normally wins. A burst limiter guarantees the CPU a slot, so neither scanout nor CPU code can starve.

---
 rtl/vram_arbiter_pkg.sv | 21 ++
 rtl/vram_arbiter_read_tag_pipe.sv | 54 +++++
 rtl/vram_arbiter.sv | 123 ++++++++++++
 tb/tb_vram_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_arbiter_pkg.sv
// Shared types for the video RAM arbiter: grant owner encoding and the
// read-return tag that travels alongside each RAM access.
package vram_arb_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_VID  = 2'd1,
    GNT_CPU  = 2'd2
  } grant_t;

  typedef struct packed {
    grant_t owner;
    logic   is_read;
  } tag_t;

  localparam tag_t TAG_IDLE = '{owner: GNT_NONE, is_read: 1'b0};

endpackage

// File: rtl/vram_arbiter_read_tag_pipe.sv
// Carries {owner, is_read} alongside each RAM access and steers the
// returning mem_rdata into the owner's rdata/rvalid registers.
module read_tag_pipe
  import vram_arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  tag_t              i_tag,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic [DATA_W-1:0] o_vid_rdata,
  output logic              o_vid_rvalid,
  output logic [DATA_W-1:0] o_cpu_rdata,
  output logic              o_cpu_rvalid
);

  tag_t              r_stage1;
  tag_t              r_stage2;
  logic [DATA_W-1:0] r_vid_rdata;
  logic              r_vid_rvalid;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic              r_cpu_rvalid;
  logic              w_vid_ret;
  logic              w_cpu_ret;

  // Stage 2 lines up with the cycle in which the RAM presents its read data.
  assign w_vid_ret = r_stage2.is_read && (r_stage2.owner == GNT_VID);
  assign w_cpu_ret = r_stage2.is_read && (r_stage2.owner == GNT_CPU);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_stage1     <= TAG_IDLE;
      r_stage2     <= TAG_IDLE;
      r_vid_rdata  <= '0;
      r_vid_rvalid <= 1'b0;
      r_cpu_rdata  <= '0;
      r_cpu_rvalid <= 1'b0;
    end else begin
      r_stage1     <= i_tag;
      r_stage2     <= r_stage1;
      r_vid_rvalid <= w_vid_ret;
      r_cpu_rvalid <= w_cpu_ret;
      if (w_vid_ret) r_vid_rdata <= i_mem_rdata;
      if (w_cpu_ret) r_cpu_rdata <= i_mem_rdata;
    end
  end

  assign o_vid_rdata  = r_vid_rdata;
  assign o_vid_rvalid = r_vid_rvalid;
  assign o_cpu_rdata  = r_cpu_rdata;
  assign o_cpu_rvalid = r_cpu_rvalid;

endmodule

// File: rtl/vram_arbiter.sv
// Single-port video RAM arbiter: video fetch normally wins, a burst limiter
// guarantees the CPU a slot; one registered RAM access per cycle at most.
module vram_arbiter
  import vram_arb_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int VID_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_ack,
  output logic [DATA_W-1:0] vid_rdata,
  output logic              vid_rvalid,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_en,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [3:0] BURST_MAX = 4'(VID_BURST);

  grant_t            r_last_grant;
  grant_t            w_next_grant;
  logic [3:0]        r_burst_cnt;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_mem_we;
  logic              r_mem_en;
  logic              w_vid_elig;
  logic              w_cpu_elig;
  tag_t              w_tag;

  // The ack cycle is a mandatory gap, so a port is never granted twice in a row.
  assign vid_ack    = (r_last_grant == GNT_VID);
  assign cpu_ack    = (r_last_grant == GNT_CPU);
  assign w_vid_elig = vid_req && !vid_ack;
  assign w_cpu_elig = cpu_req && !cpu_ack;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_last_grant <= GNT_NONE;
    end else begin
      r_last_grant <= w_next_grant;
    end
  end

  always_comb begin
    w_next_grant = GNT_NONE;
    if (w_vid_elig && w_cpu_elig) begin
      w_next_grant = (r_burst_cnt < BURST_MAX) ? GNT_VID : GNT_CPU;
    end else if (w_vid_elig) begin
      w_next_grant = GNT_VID;
    end else if (w_cpu_elig) begin
      w_next_grant = GNT_CPU;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_burst_cnt <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_we    <= 1'b0;
      r_mem_en    <= 1'b0;
    end else begin
      if (!cpu_req || (w_next_grant == GNT_CPU)) begin
        r_burst_cnt <= '0;
      end else if ((w_next_grant == GNT_VID) && (r_burst_cnt < BURST_MAX)) begin
        r_burst_cnt <= r_burst_cnt + 4'd1;
      end
      r_mem_en <= (w_next_grant != GNT_NONE);
      case (w_next_grant)
        GNT_VID: begin
          r_mem_addr <= vid_addr;
          r_mem_we   <= 1'b0;
        end
        GNT_CPU: begin
          r_mem_addr  <= cpu_addr;
          r_mem_wdata <= cpu_wdata;
          r_mem_we    <= cpu_we;
        end
        default: r_mem_we <= 1'b0;
      endcase
    end
  end

  always_comb begin
    w_tag         = TAG_IDLE;
    w_tag.owner   = w_next_grant;
    w_tag.is_read = (w_next_grant == GNT_VID) ||
                    ((w_next_grant == GNT_CPU) && !cpu_we);
  end

  read_tag_pipe #(
    .DATA_W(DATA_W)
  ) u_read_tag_pipe (
    .clk         (clk),
    .reset       (reset),
    .i_tag       (w_tag),
    .i_mem_rdata (mem_rdata),
    .o_vid_rdata (vid_rdata),
    .o_vid_rvalid(vid_rvalid),
    .o_cpu_rdata (cpu_rdata),
    .o_cpu_rvalid(cpu_rvalid)
  );

  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_we    = r_mem_we;
  assign mem_en    = r_mem_en;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural sync RAM and a
// read-return scoreboard keyed on the cycle each ack is observed.
module tb_vram_arbiter;

  localparam int AW = 16;
  localparam int DW = 8;
  localparam int VB = 4;

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          vid_req = 1'b0;
  logic [AW-1:0] vid_addr = '0;
  logic          vid_ack;
  logic [DW-1:0] vid_rdata;
  logic          vid_rvalid;
  logic          cpu_req = 1'b0;
  logic          cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_rvalid;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic          mem_en;
  logic [DW-1:0] mem_rdata = '0;

  logic [DW-1:0] ram   [0:65535];
  logic [DW-1:0] model [0:65535];
  exp_t          vq[$];
  exp_t          cq[$];
  int            cyc = 0;
  int            total = 0;
  int            bad = 0;

  vram_arbiter #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .VID_BURST(VB)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .vid_req   (vid_req),
    .vid_addr  (vid_addr),
    .vid_ack   (vid_ack),
    .vid_rdata (vid_rdata),
    .vid_rvalid(vid_rvalid),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_ack   (cpu_ack),
    .cpu_rdata (cpu_rdata),
    .cpu_rvalid(cpu_rvalid),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_en    (mem_en),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] initVal(input int a);
    if (a == 32'h1234) return 8'hA5;
    return 8'(a ^ (a >> 8) ^ 8'h5A);
  endfunction

  initial begin
    for (int a = 0; a < 65536; a++) ram[a] <= initVal(a);
  end

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor: checks each RAM access against the driven request and scores read returns.
  always @(negedge clk) begin
    if (!reset) begin
      vq.delete();
      cq.delete();
    end else begin
      checkOutput("one_ack", {31'd0, vid_ack & cpu_ack}, 0);
      if (vid_ack) begin
        checkOutput("vid_mem_en", {31'd0, mem_en}, 1);
        checkOutput("vid_mem_we", {31'd0, mem_we}, 0);
        checkOutput("vid_mem_addr", {16'd0, mem_addr}, {16'd0, vid_addr});
        vq.push_back('{data: model[vid_addr], due: cyc + 2});
      end
      if (cpu_ack) begin
        checkOutput("cpu_mem_en", {31'd0, mem_en}, 1);
        checkOutput("cpu_mem_we", {31'd0, mem_we}, {31'd0, cpu_we});
        checkOutput("cpu_mem_addr", {16'd0, mem_addr}, {16'd0, cpu_addr});
        if (cpu_we) begin
          checkOutput("cpu_mem_wdata", {24'd0, mem_wdata}, {24'd0, cpu_wdata});
          model[cpu_addr] = cpu_wdata;
        end else begin
          cq.push_back('{data: model[cpu_addr], due: cyc + 2});
        end
      end
      if (!vid_ack && !cpu_ack) begin
        checkOutput("idle_mem_en", {31'd0, mem_en}, 0);
        checkOutput("idle_mem_we", {31'd0, mem_we}, 0);
      end
      if (vq.size() > 0 && vq[0].due == cyc) begin
        checkOutput("vid_rvalid", {31'd0, vid_rvalid}, 1);
        checkOutput("vid_rdata", {24'd0, vid_rdata}, {24'd0, vq[0].data});
        void'(vq.pop_front());
      end else begin
        checkOutput("vid_rvalid_idle", {31'd0, vid_rvalid}, 0);
      end
      if (cq.size() > 0 && cq[0].due == cyc) begin
        checkOutput("cpu_rvalid", {31'd0, cpu_rvalid}, 1);
        checkOutput("cpu_rdata", {24'd0, cpu_rdata}, {24'd0, cq[0].data});
        void'(cq.pop_front());
      end else begin
        checkOutput("cpu_rvalid_idle", {31'd0, cpu_rvalid}, 0);
      end
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Issues one request, holds it until the ack is seen, then drops req.
  task automatic applyStimulus(input bit isVid, input logic we, input logic [AW-1:0] addr,
                               input logic [DW-1:0] wdata, output int reqCyc, output int ackCyc);
    if (isVid) begin
      vid_addr = addr;
      vid_req  = 1'b1;
    end else begin
      cpu_we    = we;
      cpu_addr  = addr;
      cpu_wdata = wdata;
      cpu_req   = 1'b1;
    end
    reqCyc = cyc;
    ackCyc = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (isVid ? vid_ack : cpu_ack) begin
        ackCyc = cyc;
        break;
      end
    end
    if (ackCyc < 0) checkOutput(isVid ? "vid_ack_timeout" : "cpu_ack_timeout",
                                {31'd0, isVid ? vid_ack : cpu_ack}, 1);
    @(posedge clk);
    #1;
    if (isVid) vid_req = 1'b0;
    else cpu_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int rq;
    int ak;
    int run;
    int cpuReqCyc;
    logic va;
    logic ca;

    for (int a = 0; a < 65536; a++) model[a] = initVal(a);

    // Reset held with both requesters active.
    reset    = 1'b0;
    vid_addr = 16'h0010;
    cpu_addr = 16'h0020;
    cpu_we   = 1'b0;
    vid_req  = 1'b1;
    cpu_req  = 1'b1;
    tick(1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("rst_ctrl", {26'd0, vid_ack, cpu_ack, vid_rvalid, cpu_rvalid, mem_en, mem_we}, 0);
    end
    checkOutput("rst_mem_addr", {16'd0, mem_addr}, 0);
    checkOutput("rst_mem_wdata", {24'd0, mem_wdata}, 0);
    checkOutput("rst_rdata", {16'd0, vid_rdata, cpu_rdata}, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("first_grant_vid", {30'd0, vid_ack, cpu_ack}, 32'b10);
    @(posedge clk);
    #1;
    vid_req = 1'b0;
    @(negedge clk);
    checkOutput("second_grant_cpu", {30'd0, vid_ack, cpu_ack}, 32'b01);
    @(posedge clk);
    #1;
    cpu_req = 1'b0;
    tick(5);

    // Single video read of the preloaded location.
    applyStimulus(1'b1, 1'b0, 16'h1234, 8'h00, rq, ak);
    checkOutput("vid_ack_latency", ak, rq + 1);
    @(negedge clk);
    @(negedge clk);
    checkOutput("vid_read_cycle", cyc, rq + 3);
    checkOutput("vid_read_a5", {23'd0, vid_rvalid, vid_rdata}, {23'd0, 1'b1, 8'hA5});
    checkOutput("vid_read_no_cpu_rv", {31'd0, cpu_rvalid}, 0);
    tick(3);
    checkOutput("hold_mem_addr", {15'd0, mem_en, mem_addr}, {15'd0, 1'b0, 16'h1234});

    // CPU write then read-back of the same location.
    applyStimulus(1'b0, 1'b1, 16'h8400, 8'h3C, rq, ak);
    checkOutput("cpu_wr_ack_latency", ak, rq + 1);
    tick(3);
    applyStimulus(1'b0, 1'b0, 16'h8400, 8'h00, rq, ak);
    checkOutput("cpu_rd_ack_latency", ak, rq + 1);
    @(negedge clk);
    @(negedge clk);
    checkOutput("cpu_read_cycle", cyc, rq + 3);
    checkOutput("cpu_read_3c", {23'd0, cpu_rvalid, cpu_rdata}, {23'd0, 1'b1, 8'h3C});
    checkOutput("cpu_read_no_vid_rv", {31'd0, vid_rvalid}, 0);
    tick(3);

    // CPU withdraws its write after losing to video.
    vid_addr  = 16'h0200;
    vid_req   = 1'b1;
    cpu_we    = 1'b1;
    cpu_addr  = 16'h8888;
    cpu_wdata = 8'hEE;
    cpu_req   = 1'b1;
    @(posedge clk);
    #1;
    cpu_req = 1'b0;
    @(negedge clk);
    checkOutput("wd_vid_wins", {30'd0, vid_ack, cpu_ack}, 32'b10);
    @(posedge clk);
    #1;
    vid_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("wd_no_cpu_access", {30'd0, cpu_ack, mem_en}, 0);
    end
    checkOutput("wd_ram_untouched", {24'd0, ram[16'h8888]}, {24'd0, initVal(32'h8888)});
    tick(1);

    // Both ports continuously busy: RAM fully used, CPU never starved.
    vid_addr  = 16'($urandom);
    cpu_we    = 1'($urandom_range(0, 1));
    cpu_addr  = {8'h80, 8'($urandom)};
    cpu_wdata = 8'($urandom);
    vid_req   = 1'b1;
    cpu_req   = 1'b1;
    cpuReqCyc = cyc;
    run       = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      va = vid_ack;
      ca = cpu_ack;
      if (i > 0) begin
        checkOutput("cont_mem_en", {31'd0, mem_en}, 1);
        checkOutput("cont_one_ack", {31'd0, va ^ ca}, 1);
      end
      if (va) run++;
      if (ca) begin
        checkOutput("cont_burst_run", {31'd0, run <= VB}, 1);
        checkOutput("cont_cpu_wait", {31'd0, (cyc - cpuReqCyc) <= 9}, 1);
        run = 0;
      end
      @(posedge clk);
      #1;
      if (va) vid_addr = 16'($urandom);
      if (ca) begin
        cpu_we    = 1'($urandom_range(0, 1));
        cpu_addr  = {8'h80, 8'($urandom)};
        cpu_wdata = 8'($urandom);
        cpuReqCyc = cyc;
      end
    end
    vid_req = 1'b0;
    cpu_req = 1'b0;
    tick(5);

    // Reset two cycles after a video grant drops the in-flight read.
    vid_addr = 16'h0300;
    vid_req  = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("mid_rst_vid_ack", {31'd0, vid_ack}, 1);
    @(posedge clk);
    #1;
    vid_req = 1'b0;
    reset   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("mid_rst_no_rvalid", {31'd0, vid_rvalid}, 0);
    checkOutput("mid_rst_ctrl", {26'd0, vid_ack, cpu_ack, vid_rvalid, cpu_rvalid, mem_en, mem_we}, 0);
    checkOutput("mid_rst_mem", {8'd0, mem_addr, mem_wdata}, 0);
    checkOutput("mid_rst_rdata", {16'd0, vid_rdata, cpu_rdata}, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    tick(4);
    applyStimulus(1'b1, 1'b0, 16'h1234, 8'h00, rq, ak);
    checkOutput("post_rst_ack_latency", ak, rq + 1);
    tick(4);

    checkOutput("sb_vid_drained", vq.size(), 0);
    checkOutput("sb_cpu_drained", cq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
